// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES-128 definitions for the decryptor and related blocks.
//   AES_NR      : number of rounds (10)
//   block_t     : 128-bit block, [127:120] = byte 0, column-major state
//   rcon        : round constant table Rcon[1..10]
//   xtime/gf_mul: GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1
//   sbox/inv_sbox: S-box pair, computed from the field inverse plus affine map
//   key_next/key_prev: one forward / inverse AES-128 key-schedule step
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] block_t;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic block_t key_next(input block_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo key_next: recover words 3..1 first, then word 0 needs the old w3.
    function automatic block_t key_prev(input block_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_inv_round.sv
// aes_inv_round -- one combinational AES inverse round.
//   st      : current state
//   rk      : round key for this round
//   last    : final round, skip InvMixColumns
//   st_next : InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk))
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_next
);

    // Row r of the column-major state rotates right by r positions.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return r;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    block_t ark;

    assign ark     = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    assign st_next = last ? ark : inv_mix_columns(ark);

endmodule

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter -- iterative AES-128 decryptor, one inverse round per clock.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input handshake for citxt and key (ready only in IDLE)
//   citxt, key         : ciphertext and cipher key, [127:120] = byte 0
//   out_valid/out_ready: output handshake; text held stable while out_valid
//   text               : recovered plaintext
//   busy               : high in every state except IDLE
// Optional build macro AES_DEC_KEY_CACHE_EN: remembers the last expanded key so
// a repeated key skips the 10-cycle forward key expansion.
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] citxt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] text,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    localparam logic [3:0] LAST_KEXP = 4'(AES_NR);

    state_t     state, state_n;
    block_t     st, st_n;
    block_t     rk, rk_n;
    block_t     citxt_reg, citxt_reg_n;
    block_t     text_n;
    logic [3:0] cnt, cnt_n;

    block_t     key_fwd;
    block_t     key_bwd;
    block_t     round_out;

`ifdef AES_DEC_KEY_CACHE_EN
    block_t     cache_key, cache_key_n;
    block_t     cache_key10, cache_key10_n;
    logic       cache_vld, cache_vld_n;
`endif

    // In ROUND, rk holds key_(cnt+1); stepping back yields key_cnt for this round.
    assign key_fwd = key_next(rk, rcon(cnt));
    assign key_bwd = key_prev(rk, rcon(cnt + 4'd1));

    aes_inv_round u_inv_round (
        .st      (st),
        .rk      (key_bwd),
        .last    (cnt == 4'd0),
        .st_next (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        st_n        = st;
        rk_n        = rk;
        cnt_n       = cnt;
        citxt_reg_n = citxt_reg;
        text_n      = text;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_key_n   = cache_key;
        cache_key10_n = cache_key10;
        cache_vld_n   = cache_vld;
`endif
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    citxt_reg_n = citxt;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_vld && key == cache_key) begin
                        st_n    = citxt ^ cache_key10;
                        rk_n    = cache_key10;
                        cnt_n   = LAST_KEXP - 4'd1;
                        state_n = ROUND;
                    end else begin
                        // The key is parked here at once; the flag stays low
                        // until expansion finishes, so an abort leaves no stale hit.
                        cache_key_n = key;
                        cache_vld_n = 1'b0;
                        rk_n        = key;
                        cnt_n       = 4'd1;
                        state_n     = KEXP;
                    end
`else
                    rk_n    = key;
                    cnt_n   = 4'd1;
                    state_n = KEXP;
`endif
                end
            end
            KEXP: begin
                rk_n = key_fwd;
                if (cnt == LAST_KEXP) begin
                    st_n    = citxt_reg ^ key_fwd;
                    cnt_n   = LAST_KEXP - 4'd1;
                    state_n = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_key10_n = key_fwd;
                    cache_vld_n   = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ROUND: begin
                rk_n = key_bwd;
                st_n = round_out;
                if (cnt == 4'd0) begin
                    text_n  = round_out;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            rk        <= '0;
            cnt       <= '0;
            citxt_reg <= '0;
            text      <= '0;
        end else begin
            st        <= st_n;
            rk        <= rk_n;
            cnt       <= cnt_n;
            citxt_reg <= citxt_reg_n;
            text      <= text_n;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_key   <= '0;
            cache_key10 <= '0;
            cache_vld   <= 1'b0;
        end else begin
            cache_key   <= cache_key_n;
            cache_key10 <= cache_key10_n;
            cache_vld   <= cache_vld_n;
        end
    end
`endif

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter -- directed FIPS-197 vectors, backpressure, mid-run reset,
// key-cache latency and an encrypt/decrypt loopback for aes_decrypt_iter.
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] citxt = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] text;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tsbox [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .citxt     (citxt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .text      (text),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] tsub(input logic [31:0] w);
        return {tsbox[w[31:24]], tsbox[w[23:16]], tsbox[w[15:8]], tsbox[w[7:0]]};
    endfunction

    // Reference forward AES-128 encryption (the link's transmit side).
    function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rkb;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = tsub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = tsbox[s[row + 4*((c + row) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            rkb = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb[127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic issue(input logic [127:0] k, input logic [127:0] c);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_before_issue", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        citxt    = c;
        key      = k;
        tick();
        in_valid = 1'b0;
        citxt    = ~c;
        key      = ~k;
    endtask

    task automatic wait_done(output int lat, output logic [127:0] k10);
        lat = 0;
        k10 = '0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 10) k10 = dut.rk;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("done_in_time", {127'd0, lat > 0}, 128'd1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]   p8, q8, x8;
        logic [127:0] k10, held, rk_, pt_, ct_;
        int           lat, bad;

        p8 = 8'h01;
        q8 = 8'h01;
        do begin
            p8 = p8 ^ {p8[6:0], 1'b0} ^ (p8[7] ? 8'h1b : 8'h00);
            q8 = q8 ^ {q8[6:0], 1'b0};
            q8 = q8 ^ {q8[5:0], 2'b0};
            q8 = q8 ^ {q8[3:0], 4'b0};
            if (q8[7]) q8 = q8 ^ 8'h09;
            x8 = q8 ^ {q8[6:0], q8[7]} ^ {q8[5:0], q8[7:6]} ^ {q8[4:0], q8[7:5]} ^ {q8[3:0], q8[7:4]};
            tsbox[p8] = x8 ^ 8'h63;
        end while (p8 != 8'h01);
        tsbox[0] = 8'h63;

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_text", text, 128'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // FIPS-197 C.1
        issue(C1_KEY, C1_CT);
        chk("c1_busy", {127'd0, busy}, 128'd1);
        wait_done(lat, k10);
        chk("c1_text", text, C1_PT);
        chk("c1_latency", 128'(lat), 128'd20);
        chk("c1_key10", k10, C1_K10);
        accept();
        chk("c1_in_ready_after", {127'd0, in_ready}, 128'd1);

        // FIPS-197 B
        issue(B_KEY, B_CT);
        wait_done(lat, k10);
        chk("b_text", text, B_PT);
        chk("b_latency", 128'(lat), 128'd20);
        chk("b_key10", k10, B_K10);

        // Backpressure with stray input pulses
        held = text;
        bad  = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 3) begin
                in_valid = 1'b1;
                citxt    = C1_CT;
                key      = C1_KEY;
            end
            tick();
            in_valid = 1'b0;
            if (text !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("bp_stable_cycles_bad", 128'(bad), 128'd0);
        chk("bp_text", text, B_PT);
        accept();
        chk("bp_out_valid_after", {127'd0, out_valid}, 128'd0);
        chk("bp_in_ready_after", {127'd0, in_ready}, 128'd1);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk("bp_no_extra_block", 128'(bad), 128'd0);

        // Reset in the middle of ROUND
        issue(C1_KEY, C1_CT);
        repeat (17) tick();
        chk("mid_busy_before_rst", {127'd0, busy}, 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_text", text, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        issue(C1_KEY, C1_CT);
        wait_done(lat, k10);
        chk("post_rst_text", text, C1_PT);
        chk("post_rst_latency", 128'(lat), 128'd20);
        accept();

        // Repeated key: cached build skips expansion on the second pass
        issue(C1_KEY, C1_CT);
        wait_done(lat, k10);
        chk("rep_text", text, C1_PT);
`ifdef AES_DEC_KEY_CACHE_EN
        chk("rep_latency", 128'(lat), 128'd10);
`else
        chk("rep_latency", 128'(lat), 128'd20);
`endif
        accept();
        issue(B_KEY, B_CT);
        wait_done(lat, k10);
        chk("newkey_text", text, B_PT);
        chk("newkey_latency", 128'(lat), 128'd20);
        accept();

        // All-zero key and ciphertext
        pt_ = '0;
        ct_ = enc(128'd0, pt_);
        issue(128'd0, ct_);
        wait_done(lat, k10);
        chk("zero_key_text", text, pt_);
        accept();

        // Loopback through the reference encryptor
        for (int i = 0; i < 200; i++) begin
            rk_ = {$urandom, $urandom, $urandom, $urandom};
            pt_ = {$urandom, $urandom, $urandom, $urandom};
            ct_ = enc(rk_, pt_);
            issue(rk_, ct_);
            wait_done(lat, k10);
            chk($sformatf("loop_%0d", i), text, pt_);
            accept();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES-128 decryptor. It is the inverse of the team's fully unrolled combinational encryptor.
- It runs one inverse round per clock, so it costs about 1/10 the area of an unrolled decryptor.
- It takes ciphertext and the cipher key over a valid/ready handshake. It derives the round-10 key in hardware, then walks the key schedule backwards while it decrypts.
- It sits on the receive side of the link, opposite the encryptor.

Parameters:
- none. AES-128 only, Nr = 10 fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  citxt/key are valid
- in_ready  output  1  block can accept; high only in IDLE
- citxt  input  128  ciphertext; [127:120] = FIPS-197 byte 0; column-major state
- key  input  128  cipher key; same byte order
- out_valid  output  1  text is valid
- out_ready  input  1  consumer accepts text
- text  output  128  recovered plaintext
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - text, the state register, the round-key register and the round counter all clear to 0.
- Input handshake:
  - A transfer occurs on the edge where in_valid && in_ready; call this edge E0.
  - At E0, citxt and key are captured into internal registers.
  - After E0, input changes are ignored.
- States:
  - IDLE: wait for an input transfer. On transfer -> KEXP, with rk = key and cnt = 1.
  - KEXP: forward key expansion, one round key per cycle: rk = next(rk, Rcon[cnt]), cnt++.
    - On the edge that produces key10 (cnt = 10): st = citxt_reg ^ key10, rk = key10, cnt = 9 -> ROUND.
  - ROUND: one inverse round per cycle.
    - Inverse key step: rk = prev(rk, Rcon[cnt+1]) gives key_cnt.
    - Datapath for cnt = 9..1: st = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), key_cnt)).
    - For cnt = 0: final round, same sequence without InvMixColumns, using key0.
    - The final round loads text and -> DONE.
  - DONE: out_valid = 1 and text is held stable.
    - When out_ready = 1 on an edge: out_valid = 0 -> IDLE.
    - in_ready goes high in the following cycle; there is no same-cycle reissue.
- Inverse key step, with key_i = words w0..w3 (w0 = bits 127:96):
  - w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[i], 24'h0}
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Latency:
  - out_valid rises 20 cycles after E0: 10 KEXP cycles + 10 ROUND cycles.
  - Throughput is one block per 21 cycles or more, including the DONE handshake.
- Boundary conditions:
  - out_ready held low: stay in DONE indefinitely; text does not change.
  - in_valid while busy: ignored, because in_ready = 0.
  - rst mid-KEXP, mid-ROUND or in DONE: abort immediately, return to the reset values; no partial output.
  - All-zero key and ciphertext are legal; no special casing.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- Defined:
  - Adds a 128-bit cached key, a 128-bit cached key10 and a cache-valid flag. All three clear on rst.
  - On transfer, if the flag is set and key equals the cached key: skip KEXP. st = citxt ^ cached key10 and -> ROUND directly; out_valid rises 10 cycles after E0.
  - On a miss, KEXP completion writes the cache.
- Undefined:
  - No cache registers exist; latency is always 20 cycles.

Decomposition:
- Package aes_pkg holds:
  - AES_NR = 10
  - Rcon table function
  - sbox and inv_sbox functions
  - xtime and gf_mul functions
  - the 128-bit block typedef
- Sub-module aes_inv_round: combinational, with inputs st, rk and last; output is the next st.
  - It is reused by any future pipelined decryptor.
- Forward and inverse key steps are package functions, not modules.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, citxt 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: text = 00112233445566778899aabbccddeeff; out_valid exactly 20 cycles after E0; internal key10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, citxt 3925841d02dc09fbdc118597196a0b32.
  - Required: text = 3243f6a8885a308d313198a2e0370734; key10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready = 0 for 50 cycles after out_valid, and pulse in_valid with new data during that time.
  - Required: text stable, in_ready = 0, the new data is not taken, one block completes.
- Reset at cycle 7 of ROUND, then issue vector C.1.
  - Required: outputs return to reset values within the reset cycle; the subsequent result is correct and its latency is 20.
- Loopback: 200 random key/plaintext pairs through the encryptor, then into this block.
  - Required: text == original plaintext for every pair.
- With AES_DEC_KEY_CACHE_EN defined: send C.1 twice with the same key.
  - Required: first latency 20, second latency 10, both outputs correct; a changed key gives latency 20 again.
